// File: rtl/sap_pkg.sv
// Shared SAP definitions: write-operation encoding and the default datapath width.
package sap_pkg;

  localparam int unsigned SAP_WIDTH = 8;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    INC  = 2'd1,
    SHL  = 2'd2,
    DEC  = 2'd3
  } op_t;

endpackage

// File: rtl/sap_reg_op.sv
// Combinational write-operation unit for one register.
// Ports:
//   r        current register value
//   win      W-bus data (used by LOAD)
//   op       operation select
//   result_c {cf, new}: flag bit above the new register value
module sap_reg_op
  import sap_pkg::*;
#(
  parameter int unsigned WIDTH = SAP_WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] win,
  input  op_t              op,
  output logic [WIDTH:0]   result_c
);

  localparam int unsigned RES_W = WIDTH + 1;

  // The top bit carries the carry, shifted-out bit or borrow depending on op.
  always_comb begin
    result_c = '0;
    unique case (op)
      LOAD:    result_c = {1'b0, win};
      INC:     result_c = {1'b0, r} + RES_W'(1);
      SHL:     result_c = {r, 1'b0};
      DEC:     result_c = {(r == '0), r - WIDTH'(1)};
      default: result_c = {1'b0, win};
    endcase
  end

endmodule

// File: rtl/sap_register_file.sv
// Bank of DEPTH general registers between the W bus and the adder/subtractor.
// Ports:
//   CLK, nCLR      clock, asynchronous active-low clear
//   nL, op, wsel   active-low write strobe, operation, destination register
//   win            W-bus data for LOAD
//   nE, rsel       active-low bus enable and register driven to the bus
//   wout, woe      bus data (0 when disabled) and bus output enable
//   bout           register 0, continuously, as the B operand
//   zf, cf         zero and carry flags of the last write
module sap_register_file
  import sap_pkg::*;
#(
  parameter int unsigned WIDTH  = SAP_WIDTH,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              nCLR,
  input  logic              nL,
  input  op_t               op,
  input  logic [ADDR_W-1:0] wsel,
  input  logic [WIDTH-1:0]  win,
  input  logic              nE,
  input  logic [ADDR_W-1:0] rsel,
  output logic [WIDTH-1:0]  wout,
  output logic              woe,
  output logic [WIDTH-1:0]  bout,
  output logic              zf,
  output logic              cf
);

  localparam int unsigned CMP_W = ADDR_W + 1;
  localparam logic [CMP_W-1:0] DEPTH_W = CMP_W'(DEPTH);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] cur_c;
  logic [WIDTH-1:0] rd_c;
  logic [WIDTH:0]   result_c;
  logic             wr_ok_c;

  // Destinations beyond the populated registers are ignored (non-power-of-2 DEPTH).
  assign wr_ok_c = ({1'b0, wsel} < DEPTH_W);

  // Operand fetch and bus read; unpopulated addresses read as zero.
  always_comb begin
    cur_c = '0;
    rd_c  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wsel == ADDR_W'(i)) cur_c = regs[i];
      if (rsel == ADDR_W'(i)) rd_c  = regs[i];
    end
  end

  sap_reg_op #(
    .WIDTH(WIDTH)
  ) u_op (
    .r       (cur_c),
    .win     (win),
    .op      (op),
    .result_c(result_c)
  );

  // Register storage and flags; the reset edge never writes.
  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      regs <= '{default: '0};
      zf   <= 1'b0;
      cf   <= 1'b0;
    end else if (!nL && wr_ok_c) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wsel == ADDR_W'(i)) regs[i] <= result_c[WIDTH-1:0];
      end
      zf <= (result_c[WIDTH-1:0] == '0);
      cf <= result_c[WIDTH];
    end
  end

  assign woe  = !nE;
  assign wout = nE ? '0 : rd_c;
  assign bout = regs[0];

endmodule

// File: tb/tb_sap_register_file.sv
module tb_sap_register_file;
  import sap_pkg::*;

  logic CLK = 1'b0;
  logic nCLR;

  // Instance A: WIDTH=8, DEPTH=4
  logic       a_nL, a_nE, a_woe, a_zf, a_cf;
  op_t        a_op;
  logic [1:0] a_wsel, a_rsel;
  logic [7:0] a_win, a_wout, a_bout;

  // Instance B: WIDTH=4, DEPTH=3
  logic       b_nL, b_nE, b_woe, b_zf, b_cf;
  op_t        b_op;
  logic [1:0] b_wsel, b_rsel;
  logic [3:0] b_win, b_wout, b_bout;

  always #5 CLK = ~CLK;

  sap_register_file #(.WIDTH(8), .DEPTH(4)) dut_a (
    .CLK(CLK), .nCLR(nCLR), .nL(a_nL), .op(a_op), .wsel(a_wsel), .win(a_win),
    .nE(a_nE), .rsel(a_rsel), .wout(a_wout), .woe(a_woe), .bout(a_bout),
    .zf(a_zf), .cf(a_cf)
  );

  sap_register_file #(.WIDTH(4), .DEPTH(3)) dut_b (
    .CLK(CLK), .nCLR(nCLR), .nL(b_nL), .op(b_op), .wsel(b_wsel), .win(b_win),
    .nE(b_nE), .rsel(b_rsel), .wout(b_wout), .woe(b_woe), .bout(b_bout),
    .zf(b_zf), .cf(b_cf)
  );

  // Observed signal selectors
  localparam int S_AWOUT = 0, S_AWOE = 1, S_ABOUT = 2, S_AZF = 3, S_ACF = 4;
  localparam int S_BWOUT = 5, S_BBOUT = 6, S_BZF = 7, S_BCF = 8;

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] exp;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   checks = 0;
  int   errors = 0;

  // Monitor: compares every queued expectation when the stimulus presents outputs.
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(chk_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.sel)
          S_AWOUT: act = a_wout;
          S_AWOE:  act = {7'd0, a_woe};
          S_ABOUT: act = a_bout;
          S_AZF:   act = {7'd0, a_zf};
          S_ACF:   act = {7'd0, a_cf};
          S_BWOUT: act = {4'd0, b_wout};
          S_BBOUT: act = {4'd0, b_bout};
          S_BZF:   act = {7'd0, b_zf};
          default: act = {7'd0, b_cf};
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic expect_v(input string n, input int sel, input logic [7:0] e);
    q.push_back('{n, sel, e});
  endtask

  task automatic sample;
    -> chk_ev;
    #1;
  endtask

  task automatic wr(input int inst, input op_t o, input int a, input logic [7:0] d);
    @(negedge CLK);
    if (inst == 0) begin
      a_nL = 1'b0; a_op = o; a_wsel = 2'(a); a_win = d;
    end else begin
      b_nL = 1'b0; b_op = o; b_wsel = 2'(a); b_win = 4'(d);
    end
    @(posedge CLK);
    #1;
    a_nL = 1'b1;
    b_nL = 1'b1;
  endtask

  task automatic rd(input int inst, input int a, input logic [7:0] e, input string n);
    if (inst == 0) begin
      a_nE = 1'b0; a_rsel = 2'(a);
    end else begin
      b_nE = 1'b0; b_rsel = 2'(a);
    end
    #1;
    expect_v(n, (inst == 0) ? S_AWOUT : S_BWOUT, e);
    sample();
  endtask

  task automatic flags(input int inst, input logic z, input logic c, input string n);
    expect_v({n, "_zf"}, (inst == 0) ? S_AZF : S_BZF, {7'd0, z});
    expect_v({n, "_cf"}, (inst == 0) ? S_ACF : S_BCF, {7'd0, c});
    sample();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    nCLR = 1'b0;
    a_nL = 1'b1; a_op = LOAD; a_wsel = '0; a_win = '0; a_nE = 1'b1; a_rsel = '0;
    b_nL = 1'b1; b_op = LOAD; b_wsel = '0; b_win = '0; b_nE = 1'b1; b_rsel = '0;

    // Reset state
    #2;
    rd(0, 1, 8'h00, "rst_wout");
    expect_v("rst_woe", S_AWOE, 8'h01);
    expect_v("rst_bout", S_ABOUT, 8'h00);
    sample();
    flags(0, 1'b0, 1'b0, "rst");
    @(negedge CLK);
    nCLR = 1'b1;

    // Populate, set flags, then clear between edges
    wr(0, LOAD, 1, 8'h5A);
    wr(0, LOAD, 0, 8'h33);
    wr(0, LOAD, 2, 8'hFF);
    wr(0, INC, 2, 8'h00);
    rd(0, 1, 8'h5A, "pre_clr_r1");
    expect_v("pre_clr_bout", S_ABOUT, 8'h33);
    sample();
    flags(0, 1'b1, 1'b1, "pre_clr");
    @(negedge CLK);
    #1 nCLR = 1'b0;
    #1;
    rd(0, 1, 8'h00, "clr_r1");
    expect_v("clr_bout", S_ABOUT, 8'h00);
    sample();
    flags(0, 1'b0, 1'b0, "clr");
    // A write strobe during reset must not land
    a_nL = 1'b0; a_op = LOAD; a_wsel = 2'd1; a_win = 8'h77;
    @(posedge CLK);
    #1 a_nL = 1'b1;
    @(negedge CLK);
    nCLR = 1'b1;
    rd(0, 1, 8'h00, "clr_abort_r1");

    // Load / read
    wr(0, LOAD, 0, 8'h3C);
    wr(0, LOAD, 2, 8'hA5);
    expect_v("ld_bout", S_ABOUT, 8'h3C);
    sample();
    rd(0, 2, 8'hA5, "ld_r2");
    expect_v("ld_woe", S_AWOE, 8'h01);
    sample();
    a_nE = 1'b1;
    #1;
    expect_v("ld_wout_dis", S_AWOUT, 8'h00);
    expect_v("ld_woe_dis", S_AWOE, 8'h00);
    sample();

    // Wrap-around
    wr(0, LOAD, 1, 8'hFF);
    wr(0, INC, 1, 8'h00);
    rd(0, 1, 8'h00, "inc_wrap");
    flags(0, 1'b1, 1'b1, "inc_wrap");
    wr(0, DEC, 1, 8'h00);
    rd(0, 1, 8'hFF, "dec_wrap");
    flags(0, 1'b0, 1'b1, "dec_wrap");
    wr(0, DEC, 1, 8'h00);
    rd(0, 1, 8'hFE, "dec2");
    flags(0, 1'b0, 1'b0, "dec2");

    // Shift
    wr(0, LOAD, 3, 8'h81);
    wr(0, SHL, 3, 8'h00);
    rd(0, 3, 8'h02, "shl1");
    flags(0, 1'b0, 1'b1, "shl1");
    wr(0, SHL, 3, 8'h00);
    rd(0, 3, 8'h04, "shl2");
    flags(0, 1'b0, 1'b0, "shl2");
    wr(0, LOAD, 1, 8'h80);
    wr(0, SHL, 1, 8'h00);
    rd(0, 1, 8'h00, "shl_out");
    flags(0, 1'b1, 1'b1, "shl_out");
    // Strobe idle with op=SHL: nothing moves
    @(negedge CLK);
    a_nL = 1'b1; a_op = SHL; a_wsel = 2'd3;
    repeat (3) @(posedge CLK);
    #1;
    rd(0, 3, 8'h04, "hold_r3");
    flags(0, 1'b1, 1'b1, "hold");

    // Same-cycle read and write, no bypass
    wr(0, LOAD, 2, 8'h10);
    @(negedge CLK);
    a_nE = 1'b0; a_rsel = 2'd2;
    a_nL = 1'b0; a_op = INC; a_wsel = 2'd2;
    #1;
    expect_v("rw_before", S_AWOUT, 8'h10);
    sample();
    @(posedge CLK);
    #1 a_nL = 1'b1;
    expect_v("rw_after", S_AWOUT, 8'h11);
    sample();
    // Bus loopback copy r2 -> r0
    @(negedge CLK);
    a_nE = 1'b0; a_rsel = 2'd2;
    #1;
    a_win = a_wout; a_nL = 1'b0; a_op = LOAD; a_wsel = 2'd0;
    @(posedge CLK);
    #1 a_nL = 1'b1;
    expect_v("copy_bout", S_ABOUT, 8'h11);
    sample();

    // Instance B: WIDTH=4, DEPTH=3
    wr(1, LOAD, 0, 8'h05);
    wr(1, LOAD, 2, 8'h0F);
    wr(1, LOAD, 1, 8'h0F);
    wr(1, INC, 1, 8'h00);
    rd(1, 1, 8'h00, "b_inc_wrap");
    flags(1, 1'b1, 1'b1, "b_inc_wrap");
    wr(1, LOAD, 3, 8'h07);
    wr(1, INC, 3, 8'h00);
    flags(1, 1'b1, 1'b1, "b_oob_flags");
    rd(1, 0, 8'h05, "b_oob_r0");
    rd(1, 1, 8'h00, "b_oob_r1");
    rd(1, 2, 8'h0F, "b_oob_r2");
    rd(1, 3, 8'h00, "b_rsel3");
    expect_v("b_bout", S_BBOUT, 8'h05);
    sample();

    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sap_register_file.md
# sap_register_file

Parametrised successor to the single load-only SAP register: a bank of `DEPTH` general registers of `WIDTH` bits. Each register loads from the W bus, or is incremented, shifted or decremented in place, on an active-low load strobe. One register at a time drives the W bus, and register 0 always feeds the adder/subtractor as the B operand. Zero and carry flags are registered on every write. The bank sits between the W bus and the adder/subtractor, and the controller/sequencer drives all of its control inputs.

## Interface
- `WIDTH`, 8, register and bus width (≥2)
- `DEPTH`, 4, number of registers (2..16)
- `ADDR_W`, $clog2(DEPTH), select width (derived; do not override)

- `CLK`  in  1  system clock; all state changes on the rising edge
- `nCLR`  in  1  reset, asynchronous, active-low; clears all state
- `nL`  in  1  active-low write strobe; the operation is applied on the rising `CLK` edge while low
- `op`  in  2  write operation (package enum): LOAD=0, INC=1, SHL=2, DEC=3
- `wsel`  in  ADDR_W  destination register
- `win`  in  WIDTH  W-bus data for LOAD
- `nE`  in  1  active-low bus output enable
- `rsel`  in  ADDR_W  register driven to the bus
- `wout`  out  WIDTH  bus data: the selected register when `nE`=0, else 0
- `woe`  out  1  equals `!nE`; the bus mux uses it
- `bout`  out  WIDTH  register 0, continuously, to the adder/subtractor
- `zf`  out  1  registered: last written value was zero
- `cf`  out  1  registered: carry/borrow/shift-out of the last write

## Operation
- Reset (`nCLR`=0, any time, no clock needed): all registers=0, `zf`=0, `cf`=0. `wout`=0, `woe`=!nE, `bout`=0.
- Write (`nL`=0 at the rising edge, `wsel`<DEPTH). Let `r = reg[wsel]`:
  - LOAD: new = `win`, cf = 0
  - INC: {cf,new} = r+1 (WIDTH+1-bit sum)
  - SHL: new = {r[WIDTH-2:0],1'b0}, cf = r[WIDTH-1]
  - DEC: new = r−1 mod 2^WIDTH, cf = (r==0) (borrow)
  - zf = (new==0). Only `reg[wsel]`, `zf` and `cf` change.
- `nL`=1: no register or flag changes, whatever `op` is.
- `wsel`≥DEPTH (non-power-of-2 DEPTH): the write is ignored entirely and the flags hold.
- Read is combinational: `wout = (!nE && rsel<DEPTH) ? reg[rsel] : 0`.
- Read and write to the same address in the same cycle: `wout` shows the old value until the edge and the new value after it. There is no bypass.
- Reading onto the bus and loading from the bus together (e.g. `nE`=0, `nL`=0, LOAD, `win`=`wout`) is legal and yields a register-to-register copy.
- Arithmetic wraps modulo 2^WIDTH: INC of all-ones gives 0 with zf=1 and cf=1; DEC of 0 gives all-ones with zf=0 and cf=1.

## Timing
- Write latency: 1 cycle. The value is visible on `wout`/`bout` immediately after the updating edge.
- Flags update on the same edge as the register.
- Read path: combinational from `nE`, `rsel` and register state. No clock latency.
- Reset assertion takes effect immediately. Deassertion is synchronised by the system reset logic, not by this block. The first write is accepted on the first rising edge with `nCLR`=1.
- Reset asserted mid-sequence aborts any pending write. The edge coinciding with `nCLR`=0 does not write.
- No handshake: the controller guarantees that `nL`, `op`, `wsel` and `win` are stable around the edge.

## Structure
- Shared package `sap_pkg`: `op_t` enum (LOAD/INC/SHL/DEC) and the `SAP_WIDTH`=8 default constant. The controller reuses both.
- One sub-module, `sap_reg_op`: a combinational unit taking (r, win, op) and returning {cf,new}. Register storage, write decode, read mux and flags stay in `sap_register_file`.
- Registers are stored as an array `[DEPTH]` of `WIDTH`-bit words, in a single `always` block with async reset.

## Test plan
- Reset: write 0x5A to r1, pulse `nCLR` low between edges → r1=0, `bout`=0, `zf`=`cf`=0 with no clock edge; `nE`=0, `rsel`=1 → `wout`=0x00.
- Load/read: LOAD 0x3C→r0 and 0xA5→r2 → `bout`=0x3C; `nE`=0, `rsel`=2 → `wout`=0xA5, `woe`=1; `nE`=1 → `wout`=0x00.
- Wrap: LOAD 0xFF→r1, INC r1 → r1=0x00, zf=1, cf=1; DEC r1 → 0xFF, zf=0, cf=1; DEC again → 0xFE, cf=0.
- Shift: LOAD 0x81→r3, SHL → 0x02, cf=1; SHL → 0x04, cf=0; `nL`=1 with op=SHL for 3 cycles → r3 stays 0x04 and the flags hold.
- Same-cycle: r2=0x10, `nE`=0, `rsel`=2, INC r2 → `wout`=0x10 before the edge and 0x11 after. Copy r2→r0 via bus loopback → `bout`=0x11.
- DEPTH=3, WIDTH=4: write with `wsel`=3 → no state change; `rsel`=3 → `wout`=0; INC of 0xF → 0x0, cf=1.
